mod_cache_arbiter: RTL and testbench

- Sits directly downstream of the L1 instruction and data caches. Serves both caches' block requests over one shared 64-bit memory bus.
- Arbitrates between the two caches and serializes 512-bit write blocks into bus beats. Deserializes read beats back into blocks.
- Returns each completed block or write acknowledgement to the requesting cache.
- One transaction is in flight at a time.

---
 rtl/mod_cache_arbiter.sv | 197 +++++++++++++++++++
 tb/tb_mod_cache_arbiter.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/mod_cache_arbiter.sv
`default_nettype none
// ============================================================================
// mod_cache_arbiter: shares one 64-bit memory bus between the L1 I/D caches,
// serializing write blocks and assembling read blocks. Option: ARB_DCACHE_PRIORITY_EN
// Revision: 1.0
// ============================================================================
module mod_cache_arbiter #(
  parameter int ADDRWIDTH = 64,
  parameter int BLOCKBITS = 512,
  parameter int BUSWIDTH  = 64,
  parameter int TAGWIDTH  = 13
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_reqcyc,
  input  logic [ADDRWIDTH-1:0] i_req,
  input  logic [TAGWIDTH-1:0]  i_reqtag,
  output logic                 i_reqack,
  output logic                 i_respcyc,
  output logic [BLOCKBITS-1:0] i_resp,
  output logic [TAGWIDTH-1:0]  i_resptag,
  input  logic                 i_respack,
  input  logic                 d_reqcyc,
  input  logic [ADDRWIDTH-1:0] d_req,
  input  logic [TAGWIDTH-1:0]  d_reqtag,
  input  logic [BLOCKBITS-1:0] d_reqdata,
  output logic                 d_reqack,
  output logic                 d_respcyc,
  output logic [BLOCKBITS-1:0] d_resp,
  output logic [TAGWIDTH-1:0]  d_resptag,
  input  logic                 d_respack,
  output logic                 bus_reqcyc,
  output logic [BUSWIDTH-1:0]  bus_req,
  output logic [TAGWIDTH-1:0]  bus_reqtag,
  input  logic                 bus_reqack,
  input  logic                 bus_respcyc,
  input  logic [BUSWIDTH-1:0]  bus_resp,
  input  logic [TAGWIDTH-1:0]  bus_resptag,
  output logic                 bus_respack
);
  localparam int BEATS  = BLOCKBITS / BUSWIDTH;
  localparam int C_CW   = $clog2(BEATS);
  localparam int C_OFFS = $clog2(BLOCKBITS / 8);

  localparam logic [2:0] C_IDLE    = 3'd0;
  localparam logic [2:0] C_REQ     = 3'd1;
  localparam logic [2:0] C_WDATA   = 3'd2;
  localparam logic [2:0] C_RWAIT   = 3'd3;
  localparam logic [2:0] C_WACK    = 3'd4;
  localparam logic [2:0] C_DELIVER = 3'd5;

  logic [2:0]           r_state;
  logic [C_CW-1:0]      r_count;
  logic                 r_last_d;
  logic                 r_grant_d;
  logic                 r_write;
  logic [TAGWIDTH-1:0]  r_tag;
  logic [BLOCKBITS-1:0] r_wdata;
  logic [BLOCKBITS-1:0] r_resp;
  logic                 r_i_reqack;
  logic                 r_d_reqack;
  logic                 r_respcyc;
  logic                 r_bus_reqcyc;
  logic [BUSWIDTH-1:0]  r_bus_req;
  logic [TAGWIDTH-1:0]  r_bus_reqtag;

  logic                 w_any;
  logic                 w_pick_d;
  logic [ADDRWIDTH-1:0] w_addr;
  logic [ADDRWIDTH-1:0] w_aligned;
  logic [TAGWIDTH-1:0]  w_tag;
  logic [C_CW-1:0]      w_count_nxt;
  logic                 w_respack;
  logic                 w_unused;

  assign w_any = i_reqcyc | d_reqcyc;

`ifdef ARB_DCACHE_PRIORITY_EN
  logic w_unused_last;
  assign w_pick_d      = d_reqcyc;
  assign w_unused_last = r_last_d;
`else
  // On a tie the side that was not served last wins.
  assign w_pick_d = d_reqcyc & (~i_reqcyc | ~r_last_d);
`endif

  assign w_addr      = w_pick_d ? d_req : i_req;
  assign w_aligned   = {w_addr[ADDRWIDTH-1:C_OFFS], {C_OFFS{1'b0}}};
  assign w_tag       = w_pick_d ? d_reqtag : i_reqtag;
  assign w_count_nxt = r_count + C_CW'(1);
  assign w_respack   = r_grant_d ? d_respack : i_respack;
  assign w_unused    = ^{bus_resptag, i_req[C_OFFS-1:0], d_req[C_OFFS-1:0]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= C_IDLE;
      r_count      <= '0;
      r_last_d     <= 1'b0;
      r_grant_d    <= 1'b0;
      r_write      <= 1'b0;
      r_tag        <= '0;
      r_wdata      <= '0;
      r_resp       <= '0;
      r_i_reqack   <= 1'b0;
      r_d_reqack   <= 1'b0;
      r_respcyc    <= 1'b0;
      r_bus_reqcyc <= 1'b0;
      r_bus_req    <= '0;
      r_bus_reqtag <= '0;
    end else begin
      r_i_reqack <= 1'b0;
      r_d_reqack <= 1'b0;
      case (r_state)
        C_IDLE: begin
          if (w_any) begin
            r_grant_d    <= w_pick_d;
            r_write      <= w_pick_d & d_reqtag[TAGWIDTH-1];
            r_tag        <= w_tag;
            r_wdata      <= d_reqdata;
            r_i_reqack   <= ~w_pick_d;
            r_d_reqack   <= w_pick_d;
            r_bus_reqcyc <= 1'b1;
            r_bus_req    <= BUSWIDTH'(w_aligned);
            r_bus_reqtag <= w_tag;
            r_count      <= '0;
            r_state      <= C_REQ;
          end
        end
        C_REQ: begin
          if (bus_reqack) begin
            r_count <= '0;
            if (r_write) begin
              r_bus_req <= r_wdata[BUSWIDTH-1:0];
              r_state   <= C_WDATA;
            end else begin
              r_bus_reqcyc <= 1'b0;
              r_bus_req    <= '0;
              r_state      <= C_RWAIT;
            end
          end
        end
        C_WDATA: begin
          if (r_count == C_CW'(BEATS - 1)) begin
            r_bus_reqcyc <= 1'b0;
            r_bus_req    <= '0;
            r_count      <= '0;
            r_state      <= C_WACK;
          end else begin
            r_bus_req <= r_wdata[BUSWIDTH*w_count_nxt +: BUSWIDTH];
            r_count   <= w_count_nxt;
          end
        end
        C_RWAIT: begin
          if (bus_respcyc) begin
            r_resp[BUSWIDTH*r_count +: BUSWIDTH] <= bus_resp;
            r_count <= w_count_nxt;
            if (r_count == C_CW'(BEATS - 1)) begin
              r_respcyc <= 1'b1;
              r_state   <= C_DELIVER;
            end
          end
        end
        C_WACK: begin
          if (bus_respcyc) begin
            r_resp    <= '0;
            r_respcyc <= 1'b1;
            r_state   <= C_DELIVER;
          end
        end
        C_DELIVER: begin
          if (w_respack) begin
            r_respcyc <= 1'b0;
            r_last_d  <= r_grant_d;
            r_state   <= C_IDLE;
          end
        end
        default: r_state <= C_IDLE;
      endcase
    end
  end

  assign i_reqack    = r_i_reqack;
  assign d_reqack    = r_d_reqack;
  assign i_respcyc   = r_respcyc & ~r_grant_d;
  assign d_respcyc   = r_respcyc & r_grant_d;
  assign i_resp      = i_respcyc ? r_resp : '0;
  assign d_resp      = d_respcyc ? r_resp : '0;
  assign i_resptag   = i_respcyc ? r_tag : '0;
  assign d_resptag   = d_respcyc ? r_tag : '0;
  assign bus_reqcyc  = r_bus_reqcyc;
  assign bus_req     = r_bus_req;
  assign bus_reqtag  = r_bus_reqtag;
  // Beats outside the read/ack-wait states are left unacknowledged.
  assign bus_respack = bus_respcyc & ((r_state == C_RWAIT) | (r_state == C_WACK));

endmodule
`default_nettype wire

// File: tb/tb_mod_cache_arbiter.sv
`default_nettype none
// tb_mod_cache_arbiter: table of single-side transactions plus directed
// arbitration, spurious-beat and mid-transaction reset sequences.
module tb_mod_cache_arbiter;
  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         i_reqcyc, d_reqcyc, i_reqack, d_reqack;
  logic [63:0]  i_req, d_req;
  logic [12:0]  i_reqtag, d_reqtag, i_resptag, d_resptag;
  logic [511:0] d_reqdata, i_resp, d_resp;
  logic         i_respcyc, d_respcyc, i_respack, d_respack;
  logic         bus_reqcyc, bus_reqack, bus_respcyc, bus_respack;
  logic [63:0]  bus_req, bus_resp;
  logic [12:0]  bus_reqtag, bus_resptag;
  logic         all_out_or;

  always #5 clk = ~clk;

  mod_cache_arbiter dut (
    .clk(clk), .reset(reset),
    .i_reqcyc(i_reqcyc), .i_req(i_req), .i_reqtag(i_reqtag), .i_reqack(i_reqack),
    .i_respcyc(i_respcyc), .i_resp(i_resp), .i_resptag(i_resptag), .i_respack(i_respack),
    .d_reqcyc(d_reqcyc), .d_req(d_req), .d_reqtag(d_reqtag), .d_reqdata(d_reqdata),
    .d_reqack(d_reqack), .d_respcyc(d_respcyc), .d_resp(d_resp), .d_resptag(d_resptag),
    .d_respack(d_respack),
    .bus_reqcyc(bus_reqcyc), .bus_req(bus_req), .bus_reqtag(bus_reqtag), .bus_reqack(bus_reqack),
    .bus_respcyc(bus_respcyc), .bus_resp(bus_resp), .bus_resptag(bus_resptag),
    .bus_respack(bus_respack)
  );

  assign all_out_or = |{i_reqack, d_reqack, i_respcyc, d_respcyc, i_resp, d_resp, i_resptag,
                        d_resptag, bus_reqcyc, bus_req, bus_reqtag, bus_respack};

  typedef struct {
    logic        side_d;
    logic [63:0] addr;
    logic [12:0] tag;
    logic [63:0] base;
    int          ack_delay;
    int          gap;
    logic [63:0] exp_addr;
  } vec_t;

  vec_t vecs[5];
  vec_t vd, vi, vr, vf;
  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic request(input vec_t v);
    if (v.side_d) begin
      d_reqcyc = 1'b1;
      d_req    = v.addr;
      d_reqtag = v.tag;
      for (int k = 0; k < 8; k++) d_reqdata[64*k +: 64] = v.base + 64'(k);
    end else begin
      i_reqcyc = 1'b1;
      i_req    = v.addr;
      i_reqtag = v.tag;
    end
  endtask

  task automatic wait_ack(input vec_t v);
    bit got;
    got = 1'b0;
    for (int n = 0; n < 400 && !got; n++) begin
      @(negedge clk);
      got = v.side_d ? d_reqack : i_reqack;
    end
    if (!got) chk("ack_timeout", 1'b0, 1'b1);
  endtask

  // Called on the negedge where the requester's ack is visible; runs the rest.
  task automatic serve(input vec_t v);
    logic         wr;
    logic [511:0] exp_resp;
    wr = v.side_d & v.tag[12];
    exp_resp = '0;
    chk("reqack_other", v.side_d ? i_reqack : d_reqack, 1'b0);
    chk("bus_addr", {bus_reqcyc, bus_req}, {1'b1, v.exp_addr});
    chk("bus_tag", bus_reqtag, v.tag);
    if (v.side_d) d_reqcyc = 1'b0; else i_reqcyc = 1'b0;
    repeat (v.ack_delay) begin
      @(negedge clk);
      chk("addr_hold", {bus_reqcyc, bus_req}, {1'b1, v.exp_addr});
    end
    bus_reqack = 1'b1;
    @(negedge clk);
    bus_reqack = 1'b0;
    chk("reqack_pulse", v.side_d ? d_reqack : i_reqack, 1'b0);
    if (wr) begin
      for (int k = 0; k < 8; k++) begin
        chk("wbeat", {bus_reqcyc, bus_req}, {1'b1, v.base + 64'(k)});
        @(negedge clk);
      end
      chk("wdone", bus_reqcyc, 1'b0);
      bus_respcyc = 1'b1;
      bus_resp    = '1;
      #1 chk("wack_respack", bus_respack, 1'b1);
      @(negedge clk);
      bus_respcyc = 1'b0;
    end else begin
      for (int k = 0; k < 8; k++) begin
        repeat (v.gap) begin
          chk("no_early", i_respcyc | d_respcyc, 1'b0);
          @(negedge clk);
        end
        chk("no_early", i_respcyc | d_respcyc, 1'b0);
        bus_respcyc = 1'b1;
        bus_resp    = v.base + 64'(k);
        #1 chk("rbeat_ack", bus_respack, 1'b1);
        @(negedge clk);
        bus_respcyc = 1'b0;
        exp_resp[64*k +: 64] = v.base + 64'(k);
      end
    end
    chk("resp_valid", v.side_d ? {i_respcyc, d_respcyc} : {d_respcyc, i_respcyc}, 2'b01);
    chk("resp_data", v.side_d ? d_resp : i_resp, exp_resp);
    chk("resp_tag", v.side_d ? d_resptag : i_resptag, v.tag);
    @(negedge clk);
    chk("resp_hold", v.side_d ? d_respcyc : i_respcyc, 1'b1);
    if (v.side_d) d_respack = 1'b1; else i_respack = 1'b1;
    @(negedge clk);
    d_respack = 1'b0;
    i_respack = 1'b0;
    chk("resp_drop", i_respcyc | d_respcyc, 1'b0);
  endtask

  initial begin
    i_reqcyc = 0; d_reqcyc = 0; i_req = '0; d_req = '0; i_reqtag = '0; d_reqtag = '0;
    d_reqdata = '0; i_respack = 0; d_respack = 0;
    bus_reqack = 0; bus_respcyc = 0; bus_resp = '0; bus_resptag = '0;

    vecs[0] = '{1'b1, 64'h1234_5678_9ABC_DE47, 13'h0055, 64'h0,         0, 0, 64'h1234_5678_9ABC_DE40};
    vecs[1] = '{1'b1, 64'h0000_0000_0000_1010, 13'h1003, 64'hA0,        2, 0, 64'h0000_0000_0000_1000};
    vecs[2] = '{1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 13'h0AAA, 64'h100,       5, 2, 64'hFFFF_FFFF_FFFF_FFC0};
    vecs[3] = '{1'b0, 64'h0000_0000_0000_00BF, 13'h1FFF, 64'h55,        0, 1, 64'h0000_0000_0000_0080};
    vecs[4] = '{1'b1, 64'h0000_0000_0000_007F, 13'h0001, 64'hDEAD_0000, 5, 2, 64'h0000_0000_0000_0040};

    repeat (3) @(negedge clk);
    chk("reset_outputs", all_out_or, 1'b0);
    reset = 1'b0;
    @(negedge clk);

    // Stray response beat while idle.
    bus_respcyc = 1'b1;
    bus_resp    = 64'hBAD;
    #1 chk("spurious_ack", bus_respack, 1'b0);
    repeat (3) begin
      @(negedge clk);
      chk("spurious_resp", i_respcyc | d_respcyc, 1'b0);
    end
    bus_respcyc = 1'b0;

    for (int i = 0; i < 5; i++) begin
      request(vecs[i]);
      wait_ack(vecs[i]);
      serve(vecs[i]);
    end

    // Simultaneous requests from a fresh reset: last_grant is I, so D first.
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    vd = '{1'b1, 64'h2000, 13'h0011, 64'h300, 0, 0, 64'h2000};
    vi = '{1'b0, 64'h3000, 13'h0022, 64'h400, 0, 0, 64'h3000};
    request(vi);
    request(vd);
    @(negedge clk);
    chk("arb_first_d", {i_reqack, d_reqack}, 2'b01);
    serve(vd);
    request(vd);
    @(negedge clk);
`ifdef ARB_DCACHE_PRIORITY_EN
    chk("arb_second_d", {i_reqack, d_reqack}, 2'b01);
    serve(vd);
    @(negedge clk);
    chk("arb_then_i", {i_reqack, d_reqack}, 2'b10);
    serve(vi);
`else
    chk("arb_second_i", {i_reqack, d_reqack}, 2'b10);
    serve(vi);
    @(negedge clk);
    chk("arb_then_d", {i_reqack, d_reqack}, 2'b01);
    serve(vd);
`endif

    // Reset in the middle of a read, after four beats.
    vr = '{1'b1, 64'h5000, 13'h0033, 64'h77, 0, 0, 64'h5000};
    request(vr);
    wait_ack(vr);
    d_reqcyc   = 1'b0;
    bus_reqack = 1'b1;
    @(negedge clk);
    bus_reqack = 1'b0;
    for (int k = 0; k < 4; k++) begin
      bus_respcyc = 1'b1;
      bus_resp    = 64'hF0 + 64'(k);
      @(negedge clk);
    end
    #2 reset = 1'b1;
    #1 chk("async_reset_outputs", all_out_or, 1'b0);
    @(negedge clk);
    reset       = 1'b0;
    bus_respcyc = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("aborted_no_resp", i_respcyc | d_respcyc, 1'b0);
    end
    vf = '{1'b0, 64'h6008, 13'h0044, 64'h900, 1, 1, 64'h6000};
    request(vf);
    wait_ack(vf);
    serve(vf);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
`default_nettype wire
